// File: rtl/cmd_queue_pkg.sv
// Shared types for the command path: processor count, instruction and
// address types, and the command word pushed into the issuer queue.
package cmd_queue_pkg;

  localparam int PROC_COUNT = 4;
  localparam int PROC_W     = $clog2(PROC_COUNT);
  localparam int CMDQ_DEPTH = 16;

  typedef logic [31:0] instr_t;
  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_RUN  = 2'd2,
    OP_HALT = 2'd3
  } cmd_op_e;

  typedef struct packed {
    cmd_op_e             op;
    logic [PROC_W-1:0]   proc_id;
    addr_t               addr;
    instr_t              instr;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic int occ_width(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cmd_queue_fifo_ctrl.sv
// Pointer, occupancy and error-flag control for the command queue.
// Status outputs decode only the registered count.
module fifo_ctrl #(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic             i_clr_err,
  output logic             o_wr_en,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_afull,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // A pop from a full queue frees the slot the push lands in.
  assign w_rd_acc = i_rd & ~w_empty;
  assign w_wr_acc = i_wr & (~w_full | w_rd_acc);

  assign w_ovf_set = i_wr & ~w_wr_acc;
  assign w_unf_set = i_rd & w_empty;

  assign w_count_nxt = r_count
                     + CNT_W'(w_wr_acc)
                     - CNT_W'(w_rd_acc);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // A new error in the clear cycle keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~i_clr_err);
      r_unf <= w_unf_set | (r_unf & ~i_clr_err);
    end
  end

  assign o_wr_en     = w_wr_acc;
  assign o_wr_ptr    = r_wr_ptr;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_afull     = (r_count >= CNT_W'(AFULL_THRESH));
  assign o_count     = r_count;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_unf;

endmodule

// File: rtl/cmd_queue.sv
// First-word-fall-through command FIFO between the command source
// and the issuer; the head is forced to zero while empty.
module cmd_queue
  import cmd_queue_pkg::*;
#(
  parameter int DEPTH        = CMDQ_DEPTH,
  parameter int AFULL_THRESH = 12,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [CMD_W-1:0] i_cmd,
  output logic             o_full,
  output logic             o_afull,
  input  logic             i_rd,
  output logic [CMD_W-1:0] o_cmd,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic             o_underflow,
  input  logic             i_clr_err
);

  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_empty;

  logic [CMD_W-1:0] r_mem [DEPTH];

  fifo_ctrl #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_ctrl (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr        (i_wr),
    .i_rd        (i_rd),
    .i_clr_err   (i_clr_err),
    .o_wr_en     (w_wr_en),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_empty     (w_empty),
    .o_full      (o_full),
    .o_afull     (o_afull),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always_ff @(posedge i_clk) begin
    if (w_wr_en)
      r_mem[w_wr_ptr] <= i_cmd;
  end

  assign o_empty = w_empty;
  assign o_cmd   = w_empty ? '0 : r_mem[w_rd_ptr];

endmodule

// File: tb/tb_cmd_queue.sv
// Self-checking bench for cmd_queue: directed corner cases followed by
// randomized push/pop against a queue-based reference model.
module tb_cmd_queue;
  import cmd_queue_pkg::*;

  localparam int DEPTH = CMDQ_DEPTH;
  localparam int AF    = 12;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_wr = 1'b0;
  logic             i_rd = 1'b0;
  logic             i_clr_err = 1'b0;
  logic [CMD_W-1:0] i_cmd = '0;
  logic             o_full;
  logic             o_afull;
  logic [CMD_W-1:0] o_cmd;
  logic             o_empty;
  logic [CNT_W-1:0] o_count;
  logic             o_overflow;
  logic             o_underflow;

  always #5 clk = ~clk;

  cmd_queue #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AF)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_wr        (i_wr),
    .i_cmd       (i_cmd),
    .o_full      (o_full),
    .o_afull     (o_afull),
    .i_rd        (i_rd),
    .o_cmd       (o_cmd),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow),
    .i_clr_err   (i_clr_err)
  );

  logic [CMD_W-1:0] q[$];
  bit               m_ovf;
  bit               m_unf;
  int               n_chk = 0;
  int               n_fail = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    int n;
    logic [CMD_W-1:0] head;
    n = q.size();
    head = (n > 0) ? q[0] : '0;
    chk({tag, ".count"}, 64'(o_count), 64'(n));
    chk({tag, ".empty"}, 64'(o_empty), 64'(n == 0));
    chk({tag, ".full"},  64'(o_full),  64'(n == DEPTH));
    chk({tag, ".afull"}, 64'(o_afull), 64'(n >= AF));
    chk({tag, ".cmd"},   64'(o_cmd),   64'(head));
    chk({tag, ".ovf"},   64'(o_overflow),  64'(m_ovf));
    chk({tag, ".unf"},   64'(o_underflow), 64'(m_unf));
  endtask

  function automatic logic [CMD_W-1:0] rnd_cmd();
    return CMD_W'({$urandom(), $urandom()});
  endfunction

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic cycle(string tag, bit wr, bit rd, bit clr,
                       logic [CMD_W-1:0] d);
    int n;
    bit pop, push;
    n = q.size();
    i_wr = wr; i_rd = rd; i_clr_err = clr; i_cmd = d;
    pop  = rd && (n > 0);
    push = wr && ((n < DEPTH) || pop);
    m_ovf = (wr && !push) || (m_ovf && !clr);
    m_unf = (rd && (n == 0)) || (m_unf && !clr);
    if (pop)
      void'(q.pop_front());
    if (push)
      q.push_back(d);
    @(posedge clk);
    #1;
    i_wr = 0; i_rd = 0; i_clr_err = 0;
    check_all(tag);
  endtask

  logic [CMD_W-1:0] a, b, c, x, y, last;
  logic [CMD_W-1:0] v [DEPTH];
  int pw, pr;

  initial begin
    #1 i_rst = 1'b1;
    #1;
    check_all("rst_async");
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    check_all("reset");
    repeat (3) cycle("idle", 0, 0, 0, '0);

    a = rnd_cmd(); b = rnd_cmd(); c = rnd_cmd();
    cycle("pushA", 1, 0, 0, a);
    chk("A_head", 64'(o_cmd), 64'(a));
    chk("A_cnt", 64'(o_count), 64'd1);
    cycle("pushB", 1, 0, 0, b);
    chk("B_cnt", 64'(o_count), 64'd2);
    cycle("pushC", 1, 0, 0, c);
    chk("C_cnt", 64'(o_count), 64'd3);
    cycle("pop1", 0, 1, 0, '0);
    chk("pop1_head", 64'(o_cmd), 64'(b));
    chk("pop1_cnt", 64'(o_count), 64'd2);
    cycle("pop2", 0, 1, 0, '0);
    chk("pop2_head", 64'(o_cmd), 64'(c));
    chk("pop2_cnt", 64'(o_count), 64'd1);
    cycle("pop3", 0, 1, 0, '0);
    chk("pop3_cnt", 64'(o_count), 64'd0);
    chk("pop3_empty", 64'(o_empty), 64'd1);

    for (int i = 0; i < DEPTH; i++) begin
      v[i] = rnd_cmd();
      cycle("fill", 1, 0, 0, v[i]);
      if (i == AF - 2) chk("afull_lo", 64'(o_afull), 64'd0);
      if (i == AF - 1) chk("afull_hi", 64'(o_afull), 64'd1);
      if (i == DEPTH - 2) chk("full_lo", 64'(o_full), 64'd0);
      if (i == DEPTH - 1) chk("full_hi", 64'(o_full), 64'd1);
    end
    cycle("push17", 1, 0, 0, rnd_cmd());
    chk("ovf_set", 64'(o_overflow), 64'd1);
    chk("ovf_cnt", 64'(o_count), 64'(DEPTH));
    chk("ovf_head", 64'(o_cmd), 64'(v[0]));
    cycle("clr_ovf", 0, 0, 1, '0);
    chk("ovf_clr", 64'(o_overflow), 64'd0);

    x = rnd_cmd();
    cycle("full_wr_rd", 1, 1, 0, x);
    chk("fwr_cnt", 64'(o_count), 64'(DEPTH));
    chk("fwr_ovf", 64'(o_overflow), 64'd0);
    chk("fwr_head", 64'(o_cmd), 64'(v[1]));
    last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last = o_cmd;
      cycle("drain", 0, 1, 0, '0);
    end
    chk("drain_last", 64'(last), 64'(x));
    chk("drain_empty", 64'(o_empty), 64'd1);

    y = rnd_cmd();
    cycle("empty_wr_rd", 1, 1, 0, y);
    chk("ewr_cnt", 64'(o_count), 64'd1);
    chk("ewr_cmd", 64'(o_cmd), 64'(y));
    chk("ewr_unf", 64'(o_underflow), 64'd1);
    cycle("clr_unf", 0, 0, 1, '0);
    chk("unf_clr", 64'(o_underflow), 64'd0);
    cycle("popY", 0, 1, 0, '0);
    cycle("pop_empty", 0, 1, 0, '0);
    chk("pe_unf", 64'(o_underflow), 64'd1);
    chk("pe_cnt", 64'(o_count), 64'd0);
    cycle("clr_and_err", 0, 1, 1, '0);
    chk("clr_err_wins", 64'(o_underflow), 64'd1);
    cycle("clr_unf2", 0, 0, 1, '0);

    for (int i = 0; i < 5; i++)
      cycle("pre_rst", 1, 0, 0, rnd_cmd());
    chk("pre_rst_cnt", 64'(o_count), 64'd5);
    #1 i_rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    chk("mid_rst_empty", 64'(o_empty), 64'd1);
    check_all("mid_rst");
    @(posedge clk);
    #1 i_rst = 1'b0;
    check_all("post_rst");

    for (int ph = 0; ph < 10; ph++) begin
      case (ph % 3)
        0:       begin pw = 75; pr = 30; end
        1:       begin pw = 30; pr = 75; end
        default: begin pw = 55; pr = 55; end
      endcase
      for (int k = 0; k < 1000; k++)
        cycle("rand",
              $urandom_range(0, 99) < pw,
              $urandom_range(0, 99) < pr,
              $urandom_range(0, 99) < 3,
              rnd_cmd());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
